rf_psum_dbuf_acc: RTL

A parametrised double-buffered partial-sum register file that sits between one PE's MAC and the global-buffer adder path. One bank (the active bank) serves the MAC. It supports read, overwrite and in-place accumulate, with optional saturation. The other bank (the drain bank) streams its contents upward through a valid/ready port. Zero-initialisation of a bank is a single-cycle valid-bit clear, not a DEPTH-cycle sweep. Bank swaps use a request/acknowledge handshake that waits until the drain bank is empty.

---
 rtl/rf_psum_pkg.sv | 28 ++
 rtl/rf_psum_dbuf_acc_if.sv | 31 +++
 rtl/rf_psum_bank.sv | 61 ++++++
 rtl/rf_psum_dbuf_acc.sv | 96 +++++++++
 4 files changed

// File: rtl/rf_psum_pkg.sv
// Shared types and helpers for the double-buffered partial-sum register file.
// Holds the drain FSM encoding and a width-generic saturating adder.
package rf_psum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_st_e;

  localparam int SAT_MAXW = 64;

  // Operands arrive sign-extended to SAT_MAXW; callers keep the low w bits.
  function automatic logic signed [SAT_MAXW-1:0] sat_add(
    input logic signed [SAT_MAXW-1:0] a,
    input logic signed [SAT_MAXW-1:0] b,
    input int                         w,
    input logic                       sat
  );
    logic signed [SAT_MAXW-1:0] s, mx, mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (sat && (s > mx)) return mx;
    if (sat && (s < mn)) return mn;
    return s;
  endfunction

endpackage

// File: rtl/rf_psum_dbuf_acc_if.sv
// MAC-side and drain-side signal bundle of the partial-sum register file.
// slave = the register file, master = the PE/upstream driver.
interface rf_psum_dbuf_acc_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 2
);
  logic [ADDR_BITWIDTH-1:0] mac_rd_addr;
  logic [DATA_BITWIDTH-1:0] mac_rd_data;
  logic                     mac_wr_en;
  logic                     mac_acc;
  logic [ADDR_BITWIDTH-1:0] mac_wr_addr;
  logic [DATA_BITWIDTH-1:0] mac_wr_data;
  logic                     swap_req;
  logic                     swap_ack;
  logic                     active_bank;
  logic                     drain_busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_BITWIDTH-1:0] out_data;
  logic [ADDR_BITWIDTH-1:0] out_addr;

  modport master (
    output mac_rd_addr, mac_wr_en, mac_acc, mac_wr_addr, mac_wr_data, swap_req, out_ready,
    input  mac_rd_data, swap_ack, active_bank, drain_busy, out_valid, out_data, out_addr
  );

  modport slave (
    input  mac_rd_addr, mac_wr_en, mac_acc, mac_wr_addr, mac_wr_data, swap_req, out_ready,
    output mac_rd_data, swap_ack, active_bank, drain_busy, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/rf_psum_bank.sv
// One partial-sum bank: data words plus per-entry valid bits, an accumulating
// write port with write-first read bypass, a drain read port and a 1-cycle clear.
module rf_psum_bank
  import rf_psum_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 2,
  parameter int DEPTH    = 4,
  parameter int SATURATE = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_we,
  input  logic          i_acc,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_val,
  input  logic [AW-1:0] i_dr_addr,
  output logic [DW-1:0] o_dr_val,
  input  logic          i_clr
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;

  logic          w_wr_in, w_rd_in, w_fire;
  logic [DW-1:0] w_old, w_new;

  assign w_wr_in = {1'b0, i_wr_addr} < LIM;
  assign w_rd_in = {1'b0, i_rd_addr} < LIM;
  assign w_fire  = i_we && w_wr_in;

  // Invalid entries behave as zero, so a cleared bank never needs a sweep.
  assign w_old = (w_wr_in && r_vld[i_wr_addr]) ? r_data[i_wr_addr] : '0;
  assign w_new = i_acc
    ? DW'(sat_add({{(SAT_MAXW-DW){w_old[DW-1]}}, w_old},
                  {{(SAT_MAXW-DW){i_wr_data[DW-1]}}, i_wr_data},
                  DW, SATURATE != 0))
    : i_wr_data;

  assign o_rd_val = (w_fire && (i_wr_addr == i_rd_addr)) ? w_new :
                    (w_rd_in && r_vld[i_rd_addr])         ? r_data[i_rd_addr] : '0;
  assign o_dr_val = r_vld[i_dr_addr] ? r_data[i_dr_addr] : '0;

  always_ff @(posedge clk) begin
    if (w_fire) r_data[i_wr_addr] <= w_new;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else begin
      if (i_clr)  r_vld <= '0;
      if (w_fire) r_vld[i_wr_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_psum_dbuf_acc.sv
// Double-buffered partial-sum register file: active bank serves the MAC,
// the other bank drains upstream; swaps wait for the drain to finish.
module rf_psum_dbuf_acc
  import rf_psum_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 2,
  parameter int DEPTH         = 4,
  parameter int SATURATE      = 1
) (
  input logic               clk,
  input logic               reset_n,
  rf_psum_dbuf_acc_if.slave bus
);

  localparam int             DW   = DATA_BITWIDTH;
  localparam int             AW   = ADDR_BITWIDTH;
  localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

  drain_st_e         r_state, w_state_nxt;
  logic              r_active;
  logic [AW-1:0]     r_cnt, w_cnt_nxt;
  logic [DW-1:0]     r_rd_data;
  logic              w_take, w_clr;
  logic [1:0][DW-1:0] w_rd_val, w_dr_val;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rf_psum_bank #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .SATURATE(SATURATE)
    ) u_bank (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_we      (bus.mac_wr_en && (r_active == 1'(b))),
      .i_acc     (bus.mac_acc),
      .i_wr_addr (bus.mac_wr_addr),
      .i_wr_data (bus.mac_wr_data),
      .i_rd_addr (bus.mac_rd_addr),
      .o_rd_val  (w_rd_val[b]),
      .i_dr_addr (r_cnt),
      .o_dr_val  (w_dr_val[b]),
      .i_clr     (w_clr && (r_active != 1'(b)))
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.swap_req) begin
          w_take      = 1'b1;
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          // Last handshake empties the drain bank in the same edge.
          if (r_cnt == LAST) begin
            w_clr       = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_data <= w_rd_val[r_active];
      if (w_take) r_active <= ~r_active;
    end
  end

  assign bus.mac_rd_data = r_rd_data;
  assign bus.swap_ack    = w_take;
  assign bus.active_bank = r_active;
  assign bus.out_valid   = (r_state == DRAIN);
  assign bus.drain_busy  = (r_state == DRAIN);
  assign bus.out_addr    = r_cnt;
  assign bus.out_data    = (r_state == DRAIN) ? w_dr_val[~r_active] : '0;

endmodule
